// File: rtl/aes256_axi_rdout.sv
// aes256_axi_rdout
//   Buffers 128-bit AES result blocks from the device in a small circular
//   buffer and unpacks the head entry into four 32-bit words for the AXI
//   read path, most significant word first.
// Ports:
//   S_AXI_ACLK     in   clock, rising edge
//   S_AXI_ARESETN  in   asynchronous active-low reset
//   outp_device    in   [127:0] result block from the device
//   ctrl_dataOut   in   one-cycle valid strobe for outp_device
//   soft_clr       in   synchronous flush of all control state
//   rd_pop         in   one-cycle strobe: AXI consumed the current word
//   rd_data        out  [31:0] current word (0 when empty)
//   rd_valid       out  buffer holds at least one entry
//   status         out  [0] empty [1] full [2] overflow [3] underflow
//                       [5:4] word index [15:8] level [31:16] zero
//   irq_done       out  one-cycle pulse after an entry is fully read out
module aes256_axi_rdout #(
   parameter int DEPTH = 4
) (
   input  logic         S_AXI_ACLK,
   input  logic         S_AXI_ARESETN,
   input  logic [127:0] outp_device,
   input  logic         ctrl_dataOut,
   input  logic         soft_clr,
   input  logic         rd_pop,
   output logic [31:0]  rd_data,
   output logic         rd_valid,
   output logic [31:0]  status,
   output logic         irq_done
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int LW = AW + 1;
   localparam logic [AW-1:0] P_PTR_ONE = AW'(1);
   localparam logic [LW-1:0] P_LVL_ONE = LW'(1);
   localparam logic [LW-1:0] P_FULL    = LW'(DEPTH);

   typedef enum logic [1:0] {W0 = 2'd0, W1 = 2'd1, W2 = 2'd2, W3 = 2'd3} widx_t;

   logic [127:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [LW-1:0] r_level;
   widx_t         r_widx;
   logic          r_ovf;
   logic          r_udf;
   logic          r_irq;

   widx_t         w_widx_nxt;
   logic [LW-1:0] w_level_nxt;
   logic          w_valid;
   logic          w_full;
   logic          w_pop_ok;
   logic          w_retire;
   logic          w_push_ok;
   logic [127:0]  w_head;

   assign w_valid  = (r_level != '0);
   assign w_full   = (r_level == P_FULL);
   assign w_pop_ok = rd_pop & w_valid;
   // The last word of the head entry is leaving, which frees a slot this cycle.
   assign w_retire = w_pop_ok & (r_widx == W3);
   // A push into a full buffer is still taken when the same cycle retires an entry.
   assign w_push_ok = ctrl_dataOut & (~w_full | w_retire);
   assign w_head    = r_mem[r_rptr];

   // Word-index state register.
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         r_widx <= W0;
      end else begin
         r_widx <= w_widx_nxt;
      end
   end

   // Word-index next state: advance on each accepted pop, flush to W0.
   always_comb begin
      w_widx_nxt = r_widx;
      if (soft_clr) begin
         w_widx_nxt = W0;
      end else if (w_pop_ok) begin
         case (r_widx)
            W0:      w_widx_nxt = W1;
            W1:      w_widx_nxt = W2;
            W2:      w_widx_nxt = W3;
            W3:      w_widx_nxt = W0;
            default: w_widx_nxt = W0;
         endcase
      end else begin
         w_widx_nxt = r_widx;
      end
   end

   // Level next value from accepted push and retiring pop.
   always_comb begin
      w_level_nxt = r_level;
      case ({w_push_ok, w_retire})
         2'b10:   w_level_nxt = r_level + P_LVL_ONE;
         2'b01:   w_level_nxt = r_level - P_LVL_ONE;
         default: w_level_nxt = r_level;
      endcase
   end

   // Control state: pointers, level, sticky flags and completion pulse.
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
         r_ovf   <= 1'b0;
         r_udf   <= 1'b0;
         r_irq   <= 1'b0;
      end else if (soft_clr) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
         r_ovf   <= 1'b0;
         r_udf   <= 1'b0;
         r_irq   <= 1'b0;
      end else begin
         if (w_push_ok) begin
            r_wptr <= r_wptr + P_PTR_ONE;
         end
         if (w_retire) begin
            r_rptr <= r_rptr + P_PTR_ONE;
         end
         r_level <= w_level_nxt;
         if (ctrl_dataOut && !w_push_ok) begin
            r_ovf <= 1'b1;
         end
         if (rd_pop && !w_valid) begin
            r_udf <= 1'b1;
         end
         r_irq <= w_retire;
      end
   end

   // Entry storage; contents are never cleared, only the pointers are.
   always_ff @(posedge S_AXI_ACLK) begin
      if (w_push_ok && !soft_clr) begin
         r_mem[r_wptr] <= outp_device;
      end
   end

   // Select the current 32-bit word of the head entry.
   always_comb begin
      rd_data = 32'h0;
      if (w_valid) begin
         case (r_widx)
            W0:      rd_data = w_head[127:96];
            W1:      rd_data = w_head[95:64];
            W2:      rd_data = w_head[63:32];
            W3:      rd_data = w_head[31:0];
            default: rd_data = 32'h0;
         endcase
      end else begin
         rd_data = 32'h0;
      end
   end

   assign rd_valid = w_valid;
   assign irq_done = r_irq;
   assign status   = {16'h0, {(8-LW){1'b0}}, r_level, 2'b00, r_widx,
                      r_udf, r_ovf, w_full, ~w_valid};

endmodule

// File: tb/tb_aes256_axi_rdout.sv
module tb_aes256_axi_rdout;

   logic         clk;
   logic         rst_n;
   logic [127:0] outp_device;
   logic         ctrl_dataOut;
   logic         soft_clr;
   logic         rd_pop;
   logic [31:0]  rd_data;
   logic         rd_valid;
   logic [31:0]  status;
   logic         irq_done;

   int n_checks = 0;
   int n_fail   = 0;

   aes256_axi_rdout #(.DEPTH(4)) dut (
      .S_AXI_ACLK    (clk),
      .S_AXI_ARESETN (rst_n),
      .outp_device   (outp_device),
      .ctrl_dataOut  (ctrl_dataOut),
      .soft_clr      (soft_clr),
      .rd_pop        (rd_pop),
      .rd_data       (rd_data),
      .rd_valid      (rd_valid),
      .status        (status),
      .irq_done      (irq_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Distinct block: each word is {0xA0+k, 0x0000, j} for word j.
   function automatic logic [127:0] blk(input int k);
      logic [7:0] b;
      b = 8'hA0 + 8'(k);
      return {b, 24'h000000, b, 24'h000001, b, 24'h000002, b, 24'h000003};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [127:0] d);
      outp_device  = d;
      ctrl_dataOut = 1'b1;
      step();
      ctrl_dataOut = 1'b0;
   endtask

   task automatic pop();
      rd_pop = 1'b1;
      step();
      rd_pop = 1'b0;
   endtask

   task automatic flush();
      soft_clr = 1'b1;
      step();
      soft_clr = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step();
      step();
      n_checks++;
      if (status !== 32'h0000_0001) begin n_fail++; $display("FAIL reset_status got %h exp %h", status, 32'h1); end
      n_checks++;
      if (rd_valid !== 1'b0 || rd_data !== 32'h0 || irq_done !== 1'b0) begin
         n_fail++; $display("FAIL reset_outputs got v=%b d=%h irq=%b exp 0/0/0", rd_valid, rd_data, irq_done);
      end
      #3 rst_n = 1'b1;
      step();
   endtask

   task automatic test_readout();
      logic [31:0] exp_w [4];
      int irq_cnt;
      exp_w[0] = 32'h0011_2233; exp_w[1] = 32'h4455_6677;
      exp_w[2] = 32'h8899_AABB; exp_w[3] = 32'hCCDD_EEFF;
      irq_cnt = 0;
      push(128'h00112233_44556677_8899AABB_CCDDEEFF);
      n_checks++;
      if (status !== 32'h0000_0100 || rd_valid !== 1'b1) begin
         n_fail++; $display("FAIL readout_after_push got st=%h v=%b exp %h/1", status, rd_valid, 32'h100);
      end
      for (int j = 0; j < 4; j++) begin
         n_checks++;
         if (rd_data !== exp_w[j]) begin n_fail++; $display("FAIL readout_word%0d got %h exp %h", j, rd_data, exp_w[j]); end
         pop();
         if (irq_done === 1'b1) irq_cnt++;
      end
      step();
      if (irq_done === 1'b1) irq_cnt++;
      n_checks++;
      if (irq_cnt != 1) begin n_fail++; $display("FAIL readout_irq_count got %0d exp 1", irq_cnt); end
      n_checks++;
      if (status !== 32'h0000_0001) begin n_fail++; $display("FAIL readout_status_end got %h exp %h", status, 32'h1); end
   endtask

   task automatic test_overflow();
      logic [127:0] b;
      int bad;
      for (int k = 0; k < 5; k++) push(blk(k));
      n_checks++;
      if (status !== 32'h0000_0406) begin n_fail++; $display("FAIL overflow_status got %h exp %h", status, 32'h406); end
      bad = 0;
      for (int k = 0; k < 4; k++) begin
         b = blk(k);
         for (int j = 0; j < 4; j++) begin
            if (rd_data !== b[127-32*j -: 32]) begin
               bad++;
               $display("FAIL overflow_readout blk%0d word%0d got %h exp %h", k, j, rd_data, b[127-32*j -: 32]);
            end
            pop();
         end
      end
      n_checks++;
      if (bad != 0) n_fail++;
      n_checks++;
      if (status !== 32'h0000_0005) begin n_fail++; $display("FAIL overflow_drained got %h exp %h", status, 32'h5); end
      flush();
      n_checks++;
      if (status !== 32'h0000_0001) begin n_fail++; $display("FAIL overflow_cleared got %h exp %h", status, 32'h1); end
   endtask

   task automatic test_full_w3();
      logic [127:0] b;
      for (int k = 0; k < 4; k++) push(blk(k));
      for (int j = 0; j < 3; j++) pop();
      n_checks++;
      if (status !== 32'h0000_0432) begin n_fail++; $display("FAIL fullw3_pre got %h exp %h", status, 32'h432); end
      outp_device  = blk(9);
      ctrl_dataOut = 1'b1;
      rd_pop       = 1'b1;
      step();
      ctrl_dataOut = 1'b0;
      rd_pop       = 1'b0;
      n_checks++;
      if (status !== 32'h0000_0402) begin n_fail++; $display("FAIL fullw3_post got %h exp %h", status, 32'h402); end
      n_checks++;
      if (irq_done !== 1'b1) begin n_fail++; $display("FAIL fullw3_irq got %b exp 1", irq_done); end
      b = blk(1);
      n_checks++;
      if (rd_data !== b[127:96]) begin n_fail++; $display("FAIL fullw3_head got %h exp %h", rd_data, b[127:96]); end
      for (int j = 0; j < 12; j++) pop();
      b = blk(9);
      n_checks++;
      if (rd_data !== b[127:96] || status !== 32'h0000_0100) begin
         n_fail++; $display("FAIL fullw3_new_block got d=%h st=%h exp %h/%h", rd_data, status, b[127:96], 32'h100);
      end
      flush();
   endtask

   task automatic test_simul_push_pop();
      logic [127:0] b;
      push(blk(3));
      outp_device  = blk(4);
      ctrl_dataOut = 1'b1;
      rd_pop       = 1'b1;
      step();
      ctrl_dataOut = 1'b0;
      rd_pop       = 1'b0;
      b = blk(3);
      n_checks++;
      if (status !== 32'h0000_0210 || rd_data !== b[95:64]) begin
         n_fail++; $display("FAIL simul_push_pop got st=%h d=%h exp %h/%h", status, rd_data, 32'h210, b[95:64]);
      end
      flush();
   endtask

   task automatic test_underflow();
      logic [127:0] b;
      pop();
      n_checks++;
      if (status !== 32'h0000_0009 || rd_data !== 32'h0) begin
         n_fail++; $display("FAIL underflow_empty got st=%h d=%h exp %h/0", status, rd_data, 32'h9);
      end
      outp_device  = blk(5);
      ctrl_dataOut = 1'b1;
      rd_pop       = 1'b1;
      step();
      ctrl_dataOut = 1'b0;
      rd_pop       = 1'b0;
      b = blk(5);
      n_checks++;
      if (status !== 32'h0000_0108 || rd_data !== b[127:96]) begin
         n_fail++; $display("FAIL underflow_with_push got st=%h d=%h exp %h/%h", status, rd_data, 32'h108, b[127:96]);
      end
      flush();
      n_checks++;
      if (status !== 32'h0000_0001) begin n_fail++; $display("FAIL underflow_cleared got %h exp %h", status, 32'h1); end
   endtask

   task automatic test_softclr_push();
      outp_device  = blk(6);
      ctrl_dataOut = 1'b1;
      soft_clr     = 1'b1;
      step();
      ctrl_dataOut = 1'b0;
      soft_clr     = 1'b0;
      n_checks++;
      if (status !== 32'h0000_0001 || rd_valid !== 1'b0) begin
         n_fail++; $display("FAIL softclr_push got st=%h v=%b exp %h/0", status, rd_valid, 32'h1);
      end
   endtask

   task automatic test_async_reset();
      logic [127:0] b;
      push(blk(1));
      push(blk(2));
      pop();
      pop();
      n_checks++;
      if (status !== 32'h0000_0220) begin n_fail++; $display("FAIL async_pre got %h exp %h", status, 32'h220); end
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (status !== 32'h0000_0001 || rd_valid !== 1'b0 || rd_data !== 32'h0) begin
         n_fail++; $display("FAIL async_immediate got st=%h v=%b d=%h exp %h/0/0", status, rd_valid, rd_data, 32'h1);
      end
      #3 rst_n = 1'b1;
      step();
      push(blk(7));
      b = blk(7);
      n_checks++;
      if (rd_data !== b[127:96] || status !== 32'h0000_0100) begin
         n_fail++; $display("FAIL async_new_push got d=%h st=%h exp %h/%h", rd_data, status, b[127:96], 32'h100);
      end
   endtask

   initial begin
      rst_n        = 1'b0;
      outp_device  = 128'h0;
      ctrl_dataOut = 1'b0;
      soft_clr     = 1'b0;
      rd_pop       = 1'b0;
      test_reset();
      test_readout();
      test_overflow();
      test_full_w3();
      test_simul_push_pop();
      test_underflow();
      test_softclr_push();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
